// File: rtl/issue_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : issue_pkg
//  Purpose  : Shared constants, fetch-entry layout, head decode record and
//             a constant clog2 helper for the issue queue slice.
//  Revision : 1.0 - initial release
// ============================================================================
package issue_pkg;

    localparam int ENTRY_W_DEFAULT = 99;

    // Fetch entry layout
    localparam int PRED_TAKEN  = 98;
    localparam int PRED_TGT_HI = 97;
    localparam int PRED_TGT_LO = 66;
    localparam int REFILL      = 65;
    localparam int INVALID     = 64;
    localparam int PC_HI       = 63;
    localparam int PC_LO       = 32;
    localparam int INST_HI     = 31;
    localparam int INST_LO     = 0;

    // Decoded view of one buffered instruction
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pred_target;
        logic        pred_taken;
        logic        refill;
        logic        invalid;
        logic        adel;
        logic        is_jmp;
        logic        is_hilo;
        logic        is_cop0;
        logic        is_ls;
        logic        is_ri;
        logic        check_ov;
        logic        is_tlbp;
        logic        is_tlbr;
        logic        is_tlbwi;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
    } idu_dec_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue_if
//  Purpose  : Fetch-push and dual-issue bundle of the issue queue. The slave
//             modport is the queue itself, master is fetch/decode/control.
//  Revision : 1.0 - initial release
// ============================================================================
interface issue_queue_if #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = issue_pkg::ENTRY_W_DEFAULT,
    parameter int CNT_W   = 32
);
    import issue_pkg::*;

    // Fetch side
    logic               push_1;
    logic               push_2;
    logic [ENTRY_W-1:0] push_data_1;
    logic [ENTRY_W-1:0] push_data_2;
    logic               in_ready;

    // Control
    logic               stall;
    logic               flush;
    logic               reset_ds;
    logic               cls_refetch;
    logic               single_issue;

    // Issue side
    logic               id1_valid_1;
    logic               id1_valid_2;
    logic [31:0]        id1_pc_1;
    logic [31:0]        id1_pc_2;
    logic [31:0]        id1_inst_1;
    logic [31:0]        id1_inst_2;
    logic               id1_pred_taken;
    logic [31:0]        id1_pred_target;
    logic               id1_in_delay_slot_1;
    logic               id1_in_delay_slot_2;
    logic               id1_is_inst_adel_1;
    logic               id1_is_inst_adel_2;
    logic               id1_is_i_refill_tlbl_1;
    logic               id1_is_i_refill_tlbl_2;
    logic               id1_is_i_invalid_tlbl_1;
    logic               id1_is_i_invalid_tlbl_2;
    logic               id1_is_refetch_1;
    logic               id1_is_refetch_2;

    // Status
    logic [clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0]      c_issue_cnt;
    logic [CNT_W-1:0]      p_issue_cnt;

    modport slave (
        input  push_1, push_2, push_data_1, push_data_2,
        input  stall, flush, reset_ds, cls_refetch, single_issue,
        output in_ready,
        output id1_valid_1, id1_valid_2, id1_pc_1, id1_pc_2,
        output id1_inst_1, id1_inst_2, id1_pred_taken, id1_pred_target,
        output id1_in_delay_slot_1, id1_in_delay_slot_2,
        output id1_is_inst_adel_1, id1_is_inst_adel_2,
        output id1_is_i_refill_tlbl_1, id1_is_i_refill_tlbl_2,
        output id1_is_i_invalid_tlbl_1, id1_is_i_invalid_tlbl_2,
        output id1_is_refetch_1, id1_is_refetch_2,
        output occupancy, c_issue_cnt, p_issue_cnt
    );

    modport master (
        output push_1, push_2, push_data_1, push_data_2,
        output stall, flush, reset_ds, cls_refetch, single_issue,
        input  in_ready,
        input  id1_valid_1, id1_valid_2, id1_pc_1, id1_pc_2,
        input  id1_inst_1, id1_inst_2, id1_pred_taken, id1_pred_target,
        input  id1_in_delay_slot_1, id1_in_delay_slot_2,
        input  id1_is_inst_adel_1, id1_is_inst_adel_2,
        input  id1_is_i_refill_tlbl_1, id1_is_i_refill_tlbl_2,
        input  id1_is_i_invalid_tlbl_1, id1_is_i_invalid_tlbl_2,
        input  id1_is_refetch_1, id1_is_refetch_2,
        input  occupancy, c_issue_cnt, p_issue_cnt
    );

endinterface
`default_nettype wire

// File: rtl/idu_1.sv
`default_nettype none
// ============================================================================
//  Module   : idu_1
//  Purpose  : Combinational pre-decode of one fetch entry: unpacks the entry
//             and classifies the instruction for issue pairing decisions.
//  Revision : 1.0 - initial release
// ============================================================================
module idu_1
    import issue_pkg::*;
#(
    parameter int ENTRY_W = ENTRY_W_DEFAULT
) (
    input  wire logic [ENTRY_W-1:0] i_entry,
    output idu_dec_t                o_dec
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;

    assign w_op = i_entry[INST_LO+31:INST_LO+26];
    assign w_fn = i_entry[INST_LO+5:INST_LO];
    assign w_rs = i_entry[INST_LO+25:INST_LO+21];
    assign w_rt = i_entry[INST_LO+20:INST_LO+16];
    assign w_rd = i_entry[INST_LO+15:INST_LO+11];

    // Field unpack plus opcode classification and destination register
    always_comb begin
        o_dec             = '0;
        o_dec.pc          = i_entry[PC_HI:PC_LO];
        o_dec.inst        = i_entry[INST_HI:INST_LO];
        o_dec.pred_target = i_entry[PRED_TGT_HI:PRED_TGT_LO];
        o_dec.pred_taken  = i_entry[PRED_TAKEN];
        o_dec.refill      = i_entry[REFILL];
        o_dec.invalid     = i_entry[INVALID];
        o_dec.adel        = |i_entry[PC_LO+1:PC_LO];
        o_dec.rs          = w_rs;
        o_dec.rt          = w_rt;
        case (w_op)
            6'h00: begin
                case (w_fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:                o_dec.dest = w_rd;
                    6'h20, 6'h22: begin          // add/sub trap on overflow
                        o_dec.dest     = w_rd;
                        o_dec.check_ov = 1'b1;
                    end
                    6'h08:                       o_dec.is_jmp = 1'b1;
                    6'h09: begin
                        o_dec.is_jmp = 1'b1;
                        o_dec.dest   = w_rd;
                    end
                    6'h0C, 6'h0D:                o_dec.dest = 5'd0;
                    6'h10, 6'h12: begin
                        o_dec.is_hilo = 1'b1;
                        o_dec.dest    = w_rd;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19,
                    6'h1A, 6'h1B:                o_dec.is_hilo = 1'b1;
                    default:                     o_dec.is_ri = 1'b1;
                endcase
            end
            6'h01: begin
                case (w_rt)
                    5'h00, 5'h01:                o_dec.is_jmp = 1'b1;
                    5'h10, 5'h11: begin          // branch-and-link
                        o_dec.is_jmp = 1'b1;
                        o_dec.dest   = 5'd31;
                    end
                    default:                     o_dec.is_ri = 1'b1;
                endcase
            end
            6'h02, 6'h04, 6'h05, 6'h06, 6'h07:   o_dec.is_jmp = 1'b1;
            6'h03: begin
                o_dec.is_jmp = 1'b1;
                o_dec.dest   = 5'd31;
            end
            6'h08: begin
                o_dec.dest     = w_rt;
                o_dec.check_ov = 1'b1;
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
            6'h0E, 6'h0F:                        o_dec.dest = w_rt;
            6'h10: begin
                o_dec.is_cop0 = 1'b1;
                case (w_rs)
                    5'h00:                       o_dec.dest = w_rt;
                    5'h04:                       o_dec.dest = 5'd0;
                    5'h10: begin
                        case (w_fn)
                            6'h01:               o_dec.is_tlbr  = 1'b1;
                            6'h02:               o_dec.is_tlbwi = 1'b1;
                            6'h08:               o_dec.is_tlbp  = 1'b1;
                            6'h18:               o_dec.dest     = 5'd0;
                            default:             o_dec.is_ri    = 1'b1;
                        endcase
                    end
                    default:                     o_dec.is_ri = 1'b1;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                o_dec.is_ls = 1'b1;
                o_dec.dest  = w_rt;
            end
            6'h28, 6'h29, 6'h2B:                 o_dec.is_ls = 1'b1;
            default:                             o_dec.is_ri = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/issue_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : issue_fifo
//  Purpose  : Circular instruction buffer with 2-wide push, 2-wide head peek,
//             pop of 0/1/2 entries and flush. Pushes are all-or-nothing.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_fifo
    import issue_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter int  ENTRY_W = ENTRY_W_DEFAULT,
    localparam int AW      = clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_push_1,
    input  wire logic               i_push_2,
    input  wire logic [ENTRY_W-1:0] i_data_1,
    input  wire logic [ENTRY_W-1:0] i_data_2,
    input  wire logic               i_pop_1,
    input  wire logic               i_pop_2,
    input  wire logic               i_flush,
    output logic      [ENTRY_W-1:0] o_head_0,
    output logic      [ENTRY_W-1:0] o_head_1,
    output logic      [CW-1:0]      o_count,
    output logic                    o_ready
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_wr_1;
    logic               w_wr_2;
    logic               w_rd_2;
    logic [1:0]         w_n_push;
    logic [1:0]         w_n_pop;

    // Ready only when a full pair fits, so a push never writes half a pair
    assign o_ready  = (r_count <= CW'(DEPTH - 2));
    assign w_wr_1   = i_push_1 & o_ready;
    assign w_wr_2   = w_wr_1 & i_push_2;
    assign w_rd_2   = i_pop_1 & i_pop_2;
    assign w_n_push = {1'b0, w_wr_1} + {1'b0, w_wr_2};
    assign w_n_pop  = {1'b0, i_pop_1} + {1'b0, w_rd_2};

    assign o_count  = r_count;
    assign o_head_0 = r_mem[r_rd_ptr];
    assign o_head_1 = r_mem[r_rd_ptr + AW'(1)];

    // Pointer and count update; flush empties the buffer ahead of push/pop
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_n_pop);
            r_count  <= r_count + CW'(w_n_push) - CW'(w_n_pop);
        end
    end

    // Entry storage; contents beyond the count are never qualified
    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            if (w_wr_1) r_mem[r_wr_ptr]          <= i_data_1;
            if (w_wr_2) r_mem[r_wr_ptr + AW'(1)] <= i_data_2;
        end
    end

endmodule
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue
//  Purpose  : Buffered dual-issue front end. Holds fetched entries in a
//             circular buffer and issues up to two per cycle with delay-slot,
//             refetch and pairing-hazard tracking plus issue counters.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_queue
    import issue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = ENTRY_W_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    issue_queue_if.slave  bus
);

    localparam int CW = clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] w_entry_0;
    logic [ENTRY_W-1:0] w_entry_1;
    logic [CW-1:0]      w_count;
    idu_dec_t           w_h0;
    idu_dec_t           w_h1;

    logic               w_jmp0;
    logic               w_raw;
    logic               w_hazard;
    logic               w_v1;
    logic               w_v2;
    logic               w_tlb_issue;
    logic               w_unused;

    logic               r_in_ds;
    logic               r_refetch;
    logic [CNT_W-1:0]   r_c_cnt;
    logic [CNT_W-1:0]   r_p_cnt;

    issue_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push_1 (bus.push_1),
        .i_push_2 (bus.push_2),
        .i_data_1 (bus.push_data_1),
        .i_data_2 (bus.push_data_2),
        .i_pop_1  (w_v1),
        .i_pop_2  (w_v2),
        .i_flush  (bus.flush),
        .o_head_0 (w_entry_0),
        .o_head_1 (w_entry_1),
        .o_count  (w_count),
        .o_ready  (bus.in_ready)
    );

    idu_1 #(.ENTRY_W(ENTRY_W)) u_idu_h0 (.i_entry(w_entry_0), .o_dec(w_h0));
    idu_1 #(.ENTRY_W(ENTRY_W)) u_idu_h1 (.i_entry(w_entry_1), .o_dec(w_h1));

    // A jump needs its delay slot buffered before it may leave
    assign w_jmp0 = w_h0.is_jmp;
    assign w_v1   = ~bus.stall & ~bus.flush & (w_count >= CW'(1))
                  & ~(w_jmp0 & (w_count < CW'(2)));

    assign w_raw  = (w_h0.dest != 5'd0)
                  & ((w_h0.dest == w_h1.rs) | (w_h0.dest == w_h1.rt));

    // Anything that must see slot 1 retire first, or that must own slot 1
    assign w_hazard = r_in_ds | w_raw
                    | w_h1.is_jmp | w_h1.is_hilo | w_h1.is_cop0 | w_h1.is_ls
                    | w_h1.is_ri  | w_h1.check_ov | w_h1.adel
                    | w_h1.refill | w_h1.invalid
                    | w_h0.is_tlbp | w_h0.is_tlbr | w_h0.is_tlbwi
                    | w_h0.pred_taken;

    assign w_v2 = w_v1 & (w_count >= CW'(2)) & ~bus.single_issue & ~w_hazard;

    assign w_tlb_issue = (w_v1 & (w_h0.is_tlbr | w_h0.is_tlbwi))
                       | (w_v2 & (w_h1.is_tlbr | w_h1.is_tlbwi));

    // Fields not needed for issue decisions
    assign w_unused = ^{w_h0, w_h1};

    assign bus.id1_valid_1             = w_v1;
    assign bus.id1_valid_2             = w_v2;
    assign bus.id1_pc_1                = w_h0.pc;
    assign bus.id1_pc_2                = w_h1.pc;
    assign bus.id1_inst_1              = w_h0.inst;
    assign bus.id1_inst_2              = w_h1.inst;
    assign bus.id1_pred_taken          = w_h0.pred_taken;
    assign bus.id1_pred_target         = w_h0.pred_target;
    assign bus.id1_in_delay_slot_1     = r_in_ds;
    assign bus.id1_in_delay_slot_2     = w_jmp0 & w_v2;
    assign bus.id1_is_inst_adel_1      = w_h0.adel;
    assign bus.id1_is_inst_adel_2      = w_h1.adel;
    assign bus.id1_is_i_refill_tlbl_1  = w_h0.refill;
    assign bus.id1_is_i_refill_tlbl_2  = w_h1.refill;
    assign bus.id1_is_i_invalid_tlbl_1 = w_h0.invalid;
    assign bus.id1_is_i_invalid_tlbl_2 = w_h1.invalid;
    assign bus.id1_is_refetch_1        = r_refetch;
    assign bus.id1_is_refetch_2        = r_refetch;
    assign bus.occupancy               = w_count;
    assign bus.c_issue_cnt             = r_c_cnt;
    assign bus.p_issue_cnt             = r_p_cnt;

    // Delay-slot tracker: set by a lone jump, cleared when its slot issues
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ds <= 1'b0;
        end else if (bus.flush) begin
            r_in_ds <= bus.reset_ds;
        end else if (bus.reset_ds) begin
            r_in_ds <= 1'b1;
        end else if (r_in_ds) begin
            r_in_ds <= ~w_v1;
        end else begin
            r_in_ds <= w_v1 & w_jmp0 & ~w_v2;
        end
    end

    // Refetch tracker: set by an issued TLB write/read, cleared by mem
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refetch <= 1'b0;
        end else if (r_refetch) begin
            r_refetch <= ~bus.cls_refetch;
        end else begin
            r_refetch <= w_tlb_issue;
        end
    end

    // Per-slot issue counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_cnt <= '0;
            r_p_cnt <= '0;
        end else begin
            r_c_cnt <= r_c_cnt + CNT_W'(w_v1);
            r_p_cnt <= r_p_cnt + CNT_W'(w_v2);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_queue
//  Purpose  : Directed self-checking bench for issue_queue with an in-order
//             scoreboard of pushed instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_queue;

    localparam int DEPTH   = 8;
    localparam int ENTRY_W = 99;
    localparam int CNT_W   = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    issue_queue_if #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .CNT_W(CNT_W)) bus ();

    issue_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [98:0] mk(input logic [31:0] pc, input logic [31:0] inst);
        return {1'b0, 32'h0, 1'b0, 1'b0, pc, inst};
    endfunction

    function automatic logic [31:0] addu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'h00, 6'h21};
    endfunction

    localparam logic [31:0] BEQ   = {6'h04, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] LW    = {6'h23, 5'd6, 5'd5, 16'h0000};
    localparam logic [31:0] TLBWI = 32'h4200_0002;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] inst);
        bus.push_1      = 1'b1;
        bus.push_2      = 1'b0;
        bus.push_data_1 = mk(pc, inst);
        sb.push_back('{pc: pc, inst: inst});
    endtask

    task automatic push2(input logic [31:0] pc1, input logic [31:0] i1,
                         input logic [31:0] pc2, input logic [31:0] i2, input bit accept);
        bus.push_1      = 1'b1;
        bus.push_2      = 1'b1;
        bus.push_data_1 = mk(pc1, i1);
        bus.push_data_2 = mk(pc2, i2);
        if (accept) begin
            sb.push_back('{pc: pc1, inst: i1});
            sb.push_back('{pc: pc2, inst: i2});
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s.sb: observed issue pc %0h expected no issue", tag, pc);
        end else begin
            e = sb.pop_front();
            chk({tag, ".pc"}, pc, e.pc);
            chk({tag, ".inst"}, inst, e.inst);
        end
    endtask

    // One cycle: check issue valids against expectation, score issued
    // entries, then advance past the next rising edge.
    task automatic step(input string tag, input logic e1, input logic e2);
        #1;
        chk({tag, ".v1"}, 32'(bus.id1_valid_1), 32'(e1));
        chk({tag, ".v2"}, 32'(bus.id1_valid_2), 32'(e2));
        if (bus.id1_valid_1) begin
            pop_check({tag, ".s1"}, bus.id1_pc_1, bus.id1_inst_1);
            chk({tag, ".ptk"}, 32'({bus.id1_pred_taken, bus.id1_is_i_refill_tlbl_1,
                                    bus.id1_is_i_invalid_tlbl_1}), 32'd0);
        end
        if (bus.id1_valid_2) begin
            pop_check({tag, ".s2"}, bus.id1_pc_2, bus.id1_inst_2);
            chk({tag, ".exc2"}, 32'({bus.id1_is_i_refill_tlbl_2,
                                     bus.id1_is_i_invalid_tlbl_2}), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.push_1      = 1'b0;
        bus.push_2      = 1'b0;
        bus.flush       = 1'b0;
        bus.reset_ds    = 1'b0;
        bus.cls_refetch = 1'b0;
    endtask

    initial begin
        n_cmp            = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus.push_1       = 1'b1;
        bus.push_2       = 1'b0;
        bus.push_data_1  = mk(32'hDEAD_0000, addu(5'd1, 5'd2, 5'd3));
        bus.push_data_2  = '0;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        bus.reset_ds     = 1'b0;
        bus.cls_refetch  = 1'b0;
        bus.single_issue = 1'b0;

        // Reset with a push held
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.push_1 = 1'b0;
        #1;
        chk("rst.occ",   32'(bus.occupancy), 32'd0);
        chk("rst.v1",    32'(bus.id1_valid_1), 32'd0);
        chk("rst.v2",    32'(bus.id1_valid_2), 32'd0);
        chk("rst.ready", 32'(bus.in_ready), 32'd1);
        chk("rst.ccnt",  bus.c_issue_cnt, 32'd0);
        chk("rst.pcnt",  bus.p_issue_cnt, 32'd0);

        // Independent pair issues together
        push2(32'h100, addu(5'd1, 5'd2, 5'd3), 32'h104, addu(5'd4, 5'd5, 6'd6), 1'b1);
        step("pair.push", 1'b0, 1'b0);
        chk("pair.occ2", 32'(bus.occupancy), 32'd2);
        step("pair.iss", 1'b1, 1'b1);
        chk("pair.occ0", 32'(bus.occupancy), 32'd0);
        chk("pair.ccnt", bus.c_issue_cnt, 32'd1);
        chk("pair.pcnt", bus.p_issue_cnt, 32'd1);

        // RAW dependency splits the pair
        push2(32'h108, addu(5'd1, 5'd2, 5'd3), 32'h10C, addu(5'd4, 5'd1, 5'd2), 1'b1);
        step("raw.push", 1'b0, 1'b0);
        step("raw.i1", 1'b1, 1'b0);
        step("raw.i2", 1'b1, 1'b0);

        // Single-issue mode
        bus.single_issue = 1'b1;
        push2(32'h110, addu(5'd1, 5'd2, 5'd3), 32'h114, addu(5'd4, 5'd5, 5'd6), 1'b1);
        step("si.push", 1'b0, 1'b0);
        step("si.i1", 1'b1, 1'b0);
        step("si.i2", 1'b1, 1'b0);
        bus.single_issue = 1'b0;

        // Branch waits for its delay slot, then the slot is flagged
        push1(32'h118, BEQ);
        step("ds.push", 1'b0, 1'b0);
        chk("ds.occ1", 32'(bus.occupancy), 32'd1);
        step("ds.wait", 1'b0, 1'b0);
        push1(32'h11C, LW);
        step("ds.push2", 1'b0, 1'b0);
        chk("ds.before", 32'(bus.id1_in_delay_slot_1), 32'd0);
        step("ds.beq", 1'b1, 1'b0);
        bus.stall = 1'b1;
        chk("ds.stall", 32'(bus.id1_in_delay_slot_1), 32'd1);
        step("ds.stallc", 1'b0, 1'b0);
        bus.stall = 1'b0;
        chk("ds.slot", 32'(bus.id1_in_delay_slot_1), 32'd1);
        step("ds.lw", 1'b1, 1'b0);
        chk("ds.clr", 32'(bus.id1_in_delay_slot_1), 32'd0);

        // Branch paired with its delay slot on slot 2
        push2(32'h120, BEQ, 32'h124, addu(5'd4, 5'd5, 5'd6), 1'b1);
        step("ds2.push", 1'b0, 1'b0);
        #1;
        chk("ds2.flag", 32'(bus.id1_in_delay_slot_2), 32'd1);
        step("ds2.iss", 1'b1, 1'b1);
        chk("ds2.after", 32'(bus.id1_in_delay_slot_1), 32'd0);

        // Fill to 7 under stall, dropped push, then flush with a push
        bus.stall = 1'b1;
        push1(32'h200, addu(5'd1, 5'd2, 5'd3));
        step("full.p1", 1'b0, 1'b0);
        push2(32'h204, addu(5'd4, 5'd5, 5'd6), 32'h208, addu(5'd7, 5'd5, 5'd6), 1'b1);
        step("full.p3", 1'b0, 1'b0);
        chk("full.rdy5", 32'(bus.in_ready), 32'd1);
        push2(32'h20C, addu(5'd8, 5'd5, 5'd6), 32'h210, addu(5'd9, 5'd5, 5'd6), 1'b1);
        step("full.p5", 1'b0, 1'b0);
        push2(32'h214, addu(5'd10, 5'd5, 5'd6), 32'h218, addu(5'd11, 5'd5, 5'd6), 1'b1);
        step("full.p7", 1'b0, 1'b0);
        chk("full.occ7", 32'(bus.occupancy), 32'd7);
        chk("full.rdy7", 32'(bus.in_ready), 32'd0);
        push2(32'h21C, addu(5'd12, 5'd5, 5'd6), 32'h220, addu(5'd13, 5'd5, 5'd6), 1'b0);
        step("full.drop", 1'b0, 1'b0);
        chk("full.occd", 32'(bus.occupancy), 32'd7);
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        push2(32'h224, addu(5'd1, 5'd2, 5'd3), 32'h228, addu(5'd4, 5'd5, 5'd6), 1'b0);
        sb.delete();
        step("flush", 1'b0, 1'b0);
        chk("flush.occ", 32'(bus.occupancy), 32'd0);
        chk("flush.rdy", 32'(bus.in_ready), 32'd1);
        chk("flush.ccnt", bus.c_issue_cnt, 32'd8);
        chk("flush.pcnt", bus.p_issue_cnt, 32'd2);

        // Refetch set by tlbwi, cleared by cls_refetch
        push2(32'h300, TLBWI, 32'h304, addu(5'd4, 5'd5, 5'd6), 1'b1);
        step("rf.push", 1'b0, 1'b0);
        chk("rf.pre", 32'(bus.id1_is_refetch_1), 32'd0);
        step("rf.tlb", 1'b1, 1'b0);
        chk("rf.set", 32'(bus.id1_is_refetch_1), 32'd1);
        push2(32'h308, addu(5'd1, 5'd2, 5'd3), 32'h30C, addu(5'd4, 5'd5, 5'd6), 1'b1);
        step("rf.i1", 1'b1, 1'b0);
        chk("rf.r1", 32'(bus.id1_is_refetch_1), 32'd1);
        chk("rf.r2", 32'(bus.id1_is_refetch_2), 32'd1);
        bus.cls_refetch = 1'b1;
        step("rf.pair", 1'b1, 1'b1);
        chk("rf.clr", 32'(bus.id1_is_refetch_1), 32'd0);

        // Misaligned PC on head 1 blocks pairing
        push2(32'h400, addu(5'd1, 5'd2, 5'd3), 32'h402, addu(5'd4, 5'd5, 5'd6), 1'b1);
        step("adel.push", 1'b0, 1'b0);
        chk("adel.h0", 32'(bus.id1_is_inst_adel_1), 32'd0);
        step("adel.i1", 1'b1, 1'b0);
        chk("adel.h0b", 32'(bus.id1_is_inst_adel_1), 32'd1);
        step("adel.i2", 1'b1, 1'b0);

        chk("end.ccnt", bus.c_issue_cnt, 32'd13);
        chk("end.pcnt", bus.p_issue_cnt, 32'd3);
        chk("end.occ", 32'(bus.occupancy), 32'd0);
        chk("end.sb", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Parametrised successor to the current dual-issue front end.
- Adds an internal DEPTH-entry circular instruction buffer between fetch and the decode/issue stage.
- Supports a runtime single-issue mode and flush.
- Issues up to two instructions per cycle to the iduc (slot 1) and idup (slot 2) paths, with delay-slot, refetch and pairing-hazard tracking, plus issue performance counters.

Parameters:
- DEPTH, 8, buffer entries; power of two, ≥4.
- ENTRY_W, 99, fetch entry width; layout comes from the package.
- CNT_W, 32, issue counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- push_1  in  1  write entry 1 this cycle.
- push_2  in  1  write entry 2 this cycle; only legal with push_1.
- push_data_1  in  ENTRY_W  fetch entry 1; older of the two.
- push_data_2  in  ENTRY_W  fetch entry 2.
- in_ready  out  1  buffer can accept two entries.
- stall  in  1  downstream stall; no issue this cycle.
- flush  in  1  discard all buffered entries.
- reset_ds  in  1  force delay-slot state for the next issued instruction.
- cls_refetch  in  1  refetch resolved, from mem.
- single_issue  in  1  mode: slot 2 never issues.
- id1_valid_1/_2  out  1  slot issues this cycle; also pops the entry.
- id1_pc_1/_2  out  32  PC.
- id1_inst_1/_2  out  32  instruction word.
- id1_pred_taken  out  1  slot-1 prediction taken.
- id1_pred_target  out  32  slot-1 predicted target.
- id1_in_delay_slot_1/_2  out  1  delay-slot flag.
- id1_is_inst_adel_1/_2  out  1  PC[1:0]≠0.
- id1_is_i_refill_tlbl_1/_2  out  1  fetch TLB refill exception.
- id1_is_i_invalid_tlbl_1/_2  out  1  fetch TLB invalid exception.
- id1_is_refetch_1/_2  out  1  refetch state.
- occupancy  out  clog2(DEPTH)+1  current entry count.
- c_issue_cnt  out  CNT_W  slot-1 issue count.
- p_issue_cnt  out  CNT_W  slot-2 issue count.

Behaviour:
- Reset (synchronous, active-high):
  - Read/write pointers and count = 0; in_ds = 0; refetch = 0; both counters = 0.
  - All id1_valid = 0; in_ready = 1.
- Buffer:
  - Circular; count width clog2(DEPTH)+1.
  - in_ready = count ≤ DEPTH-2, combinational from registered count.
  - A push while in_ready=0 is dropped entirely; no partial write.
  - Push-to-visible latency is 1 cycle; no bypass.
  - Same-cycle push and pop is legal: count_next = count + pushes − pops.
  - Pointers wrap modulo DEPTH.
- Heads:
  - h0 = entry at rd_ptr; h1 = entry at rd_ptr+1 (wrapped).
  - Each head is decoded combinationally by an idu_1 instance.
  - Head outputs are driven whenever the entry exists and are don't-care otherwise; id1_valid qualifies them.
- Slot-1 issue:
  - id1_valid_1 = ~stall & count≥1 & ~(jmp0 & count<2).
  - jmp0 = h0 is branch, j-immediate or jr.
- Slot-2 issue: id1_valid_2 = id1_valid_1 & count≥2 & ~single_issue & ~hazard.
- hazard is the OR of:
  - in_ds;
  - RAW: h0 writes a nonzero register equal to h1.rs or h1.rt;
  - h1 is jmp, hilo, cop0, load/store, reserved instruction, check_ov, inst_adel, refill or invalid;
  - h0 is tlbp, tlbr or tlbwi;
  - h0 pred_taken.
- Pop = id1_valid_1 + id1_valid_2.
- Delay-slot state:
  - id1_in_delay_slot_1 = in_ds.
  - id1_in_delay_slot_2 = jmp0 & id1_valid_2.
  - in_ds_next = reset_ds ? 1 : in_ds ? ~id1_valid_1 : (id1_valid_1 & jmp0 & ~id1_valid_2).
  - in_ds is held across stall and across empty cycles.
- Refetch state:
  - refetch_next = refetch ? ~cls_refetch : (issued slot is tlbr or tlbwi).
  - id1_is_refetch_1/_2 = refetch.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next state: count = 0, both pointers = 0, in_ds = reset_ds.
  - id1_valid_1/_2 are forced to 0 in the flush cycle.
  - refetch and the counters are unaffected.
- Counters: increment on id1_valid_1 / id1_valid_2 respectively; wrap modulo 2^CNT_W.
- Reset mid-operation discards all entries; no output glitch requirement beyond returning to reset values in the next cycle.

Decomposition:
- Package issue_pkg:
  - Entry field offsets: PRED_TAKEN = 98, PRED_TGT = 97:66, REFILL = 65, INVALID = 64, PC = 63:32, INST = 31:0.
  - ENTRY_W default.
  - Function clog2.
- Sub-module issue_fifo: circular buffer with 2-wide push, 2-wide head peek, pop of 0/1/2, flush, count.
- Reuse the existing idu_1 twice for head decode.

Test Plan:
- Reset with push_1=1 held → after release: occupancy=0, id1_valid_1/_2=0, in_ready=1, counters 0.
- Push addu $1,$2,$3 and addu $4,$5,$6 (DEPTH=8) → next cycle id1_valid_1=1 and id1_valid_2=1, occupancy→0, c_issue_cnt=1, p_issue_cnt=1.
- RAW conflict:
  - Stimulus: push addu $1,$2,$3 and addu $4,$1,$2.
  - Required: slot 1 only; next cycle the second addu issues on slot 1.
  - single_issue=1 with independent instructions → never id1_valid_2.
- Delay slot with blocked pairing:
  - Stimulus: push beq alone → no issue while occupancy=1; then push lw.
  - Required: beq issues alone, in_ds=1; next cycle lw issues with id1_in_delay_slot_1=1.
  - With stall=1 in between, in_ds stays 1.
- Full buffer and flush:
  - stall=1, push pairs: in_ready=0 at occupancy 7; further push dropped, occupancy stays 7.
  - flush+push in the same cycle → occupancy 0.
- Refetch: tlbwi issues → id1_is_refetch=1 on all later issues; cls_refetch pulse → 0 the following cycle.
